// File: rtl/par_ser_sched_if.sv
// Requester/converter bundle for the parallel-to-serial scheduler.
// The master side is the requester/converter environment; the slave side is the scheduler.
interface par_ser_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       ack;
  logic                   ser_strobe;
  logic [WIDTH-1:0]       ser_data;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output req, data,
    input  ack, ser_strobe, ser_data, grant_id, busy, frame_done
  );

  modport slave (
    input  req, data,
    output ack, ser_strobe, ser_data, grant_id, busy, frame_done
  );
endinterface

// File: rtl/par_ser_sched.sv
// Round-robin scheduler sharing one parallel-to-serial converter among N_REQ byte producers.
// One frame = LOAD (1 cycle) + SHIFT (SHIFT_LEN cycles) + GAP (GAP_LEN cycles).
module par_ser_sched #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int SHIFT_LEN = 8,
  parameter int GAP_LEN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  par_ser_sched_if.slave bus
);
  localparam int ID_W    = $clog2(N_REQ);
  localparam int MAX_LEN = (SHIFT_LEN > GAP_LEN) ? SHIFT_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   grant_q;
  logic [WIDTH-1:0]  ser_data_q;
  logic [ID_W-1:0]   win;
  logic              load;

  // First set request bit at or above p, wrapping around; lowest offset wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] w;
    int              idx;
    w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N_REQ;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

  assign win = rr_pick(bus.req, ptr);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = LOAD;
          load      = 1'b1;
          ptr_nxt   = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        end
      end
      LOAD: begin
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (GAP_LEN > 0) ? GAP : IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      grant_q    <= '0;
      ser_data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      if (load) begin
        grant_q    <= win;
        ser_data_q <= bus.data[win*WIDTH +: WIDTH];
      end
    end
  end

  // Pulses decode straight from state so an asynchronous reset clears them at once.
  assign bus.ack        = (state == LOAD) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign bus.ser_strobe = (state == LOAD);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == SHIFT) && (cnt == SHIFT_LAST);
  assign bus.ser_data   = ser_data_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_par_ser_sched.sv
// Bench for par_ser_sched: frame-timing model compared every cycle, plus directed literal checks.
module tb_par_ser_sched;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  par_ser_sched_if #(.N_REQ(4), .WIDTH(8)) bus1 ();
  par_ser_sched_if #(.N_REQ(4), .WIDTH(8)) bus2 ();

  par_ser_sched #(.N_REQ(4), .WIDTH(8), .SHIFT_LEN(8), .GAP_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  par_ser_sched #(.N_REQ(4), .WIDTH(8), .SHIFT_LEN(3), .GAP_LEN(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, k + 1, act, exp, $time);
    end
  endtask

  // Frame-timing model: a frame starting (LOAD) at cycle fs occupies fs..fs+S+G.
  int               cyc;
  int               fs     [2];
  int               ptr_m  [2];
  logic [7:0]       ed     [2];
  logic [1:0]       eg     [2];
  int               s_len  [2] = '{8, 3};
  int               g_len  [2] = '{1, 0};
  int               glog1  [$];
  int               st2    [$];

  initial begin
    logic [3:0]  a_ack   [2];
    logic        a_stb   [2];
    logic [7:0]  a_sd    [2];
    logic [1:0]  a_gid   [2];
    logic        a_busy  [2];
    logic        a_done  [2];
    logic [3:0]  a_req   [2];
    logic [31:0] a_data  [2];
    int          off;
    logic        inf;
    int          w;
    logic        found;
    int          idx;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      fs[k] = -1000; ptr_m[k] = 0; ed[k] = '0; eg[k] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      a_ack[0] = bus1.ack; a_stb[0] = bus1.ser_strobe; a_sd[0] = bus1.ser_data;
      a_gid[0] = bus1.grant_id; a_busy[0] = bus1.busy; a_done[0] = bus1.frame_done;
      a_req[0] = bus1.req; a_data[0] = bus1.data;
      a_ack[1] = bus2.ack; a_stb[1] = bus2.ser_strobe; a_sd[1] = bus2.ser_data;
      a_gid[1] = bus2.grant_id; a_busy[1] = bus2.busy; a_done[1] = bus2.frame_done;
      a_req[1] = bus2.req; a_data[1] = bus2.data;
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          fs[k] = -1000; ptr_m[k] = 0; ed[k] = '0; eg[k] = '0;
        end
        off = cyc - fs[k];
        inf = (fs[k] >= 0) && (off >= 0) && (off <= s_len[k] + g_len[k]);
        chk("strobe", k, 32'(a_stb[k]), 32'(inf && off == 0));
        chk("ack", k, 32'(a_ack[k]), (inf && off == 0) ? (32'd1 << eg[k]) : 32'd0);
        chk("busy", k, 32'(a_busy[k]), 32'(inf));
        chk("frame_done", k, 32'(a_done[k]), 32'(inf && off == s_len[k]));
        chk("ser_data", k, 32'(a_sd[k]), 32'(ed[k]));
        chk("grant_id", k, 32'(a_gid[k]), 32'(eg[k]));
        if (a_stb[k]) begin
          if (k == 0) glog1.push_back(int'(a_gid[k]));
          else        st2.push_back(cyc);
        end
        if (rst && !inf && a_req[k] != 4'b0) begin
          found = 1'b0; w = 0;
          for (int i = 0; i < 4; i++) begin
            idx = (ptr_m[k] + i) % 4;
            if (!found && a_req[k][idx]) begin found = 1'b1; w = idx; end
          end
          fs[k]    = cyc + 1;
          ed[k]    = a_data[k][w*8 +: 8];
          eg[k]    = 2'(w);
          ptr_m[k] = (w + 1) % 4;
        end
      end
    end
  end

  task automatic run_cycles(input int n, input logic [3:0] drop);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus1.req = bus1.req & ~(bus1.ack & drop);
    end
  endtask

  initial begin
    int exp3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.req = '0; bus1.data = '0;
    bus2.req = '0; bus2.data = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 0, 32'(bus1.busy), 32'd0);
    chk("rst_ser_data", 0, 32'(bus1.ser_data), 32'd0);
    chk("rst_strobe", 0, 32'(bus1.ser_strobe), 32'd0);
    rst = 1'b1;
    run_cycles(2, 4'hF);

    // Single request
    bus1.data = {8'h44, 8'h33, 8'h22, 8'hA5};
    bus1.req  = 4'b0001;
    @(posedge clk); #1;
    chk("t1_ack", 0, 32'(bus1.ack), 32'h1);
    chk("t1_strobe", 0, 32'(bus1.ser_strobe), 32'h1);
    chk("t1_ser_data", 0, 32'(bus1.ser_data), 32'hA5);
    chk("t1_grant", 0, 32'(bus1.grant_id), 32'h0);
    bus1.req = bus1.req & ~bus1.ack;
    run_cycles(14, 4'hF);

    // Simultaneous requests, pointer at 1 after the previous grant
    glog1.delete();
    bus1.data = {8'hD3, 8'h00, 8'h7E, 8'h00};
    bus1.req  = 4'b1010;
    run_cycles(30, 4'hF);
    chk("t2_nframes", 0, 32'(glog1.size()), 32'd2);
    if (glog1.size() == 2) begin
      chk("t2_first", 0, 32'(glog1[0]), 32'd1);
      chk("t2_second", 0, 32'(glog1[1]), 32'd3);
    end

    // Fairness with all requesters held high
    glog1.delete();
    bus1.data = {8'h04, 8'h03, 8'h02, 8'h01};
    bus1.req  = 4'b1111;
    run_cycles(80, 4'h0);
    bus1.req = 4'b0000;
    run_cycles(15, 4'h0);
    chk("t3_nframes", 0, 32'(glog1.size()), 32'd8);
    if (glog1.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_seq", 0, 32'(glog1[i]), 32'(exp3[i]));

    // Request raised and dropped while the converter is busy
    glog1.delete();
    bus1.data = {8'h00, 8'hEE, 8'h00, 8'h5C};
    bus1.req  = 4'b0001;
    run_cycles(3, 4'hF);
    bus1.req[2] = 1'b1;
    run_cycles(4, 4'h0);
    bus1.req[2] = 1'b0;
    run_cycles(12, 4'hF);
    chk("t4_nframes", 0, 32'(glog1.size()), 32'd1);
    chk("t4_busy_idle", 0, 32'(bus1.busy), 32'd0);

    // Asynchronous reset in the middle of SHIFT
    bus1.req = 4'b0001;
    run_cycles(6, 4'hF);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", 0, 32'(bus1.busy), 32'd0);
    chk("t5_ser_data", 0, 32'(bus1.ser_data), 32'd0);
    chk("t5_ack", 0, 32'(bus1.ack), 32'd0);
    chk("t5_done", 0, 32'(bus1.frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus1.data = {8'h99, 8'h5A, 8'h00, 8'h11};
    bus1.req  = 4'b1001;
    @(posedge clk); #1;
    chk("t5_ptr_grant", 0, 32'(bus1.grant_id), 32'd0);
    chk("t5_ptr_data", 0, 32'(bus1.ser_data), 32'h11);
    bus1.req = 4'b0000;
    run_cycles(12, 4'hF);
    bus1.req = 4'b0100;
    @(posedge clk); #1;
    chk("t5_grant", 0, 32'(bus1.grant_id), 32'd2);
    chk("t5_data", 0, 32'(bus1.ser_data), 32'h5A);
    bus1.req = bus1.req & ~bus1.ack;
    run_cycles(12, 4'hF);

    // No gap, short shift on the second instance
    st2.delete();
    bus2.data = 32'h0000_003C;
    bus2.req  = 4'b0001;
    repeat (21) begin @(posedge clk); #1; end
    bus2.req = 4'b0000;
    repeat (8) begin @(posedge clk); #1; end
    chk("t6_nframes", 1, 32'(st2.size()), 32'd5);
    for (int i = 1; i < st2.size(); i++)
      chk("t6_spacing", 1, 32'(st2[i] - st2[i-1]), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_ser_sched.md
Name: par_ser_sched

Overview:
- Round-robin scheduler that shares one 8-bit parallel-to-serial converter among N_REQ requesters.
- For each frame it:
  - arbitrates among pending requesters;
  - latches the winner's byte onto the converter's parallel input;
  - issues a one-cycle load strobe;
  - holds off further grants for the shift time plus an inter-frame gap.
- Sits between byte producers and a par_ser instance: ser_data drives d_in, ser_strobe drives strobe.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, byte width of each requester's data and of ser_data
- SHIFT_LEN, 8, cycles the converter needs to shift out one word (>=1)
- GAP_LEN, 1, idle cycles inserted after the shift before the next arbitration (>=0)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  N_REQ  per-requester request level
- data  in  N_REQ*WIDTH  flattened request bytes; requester i uses bits [i*WIDTH +: WIDTH]
- ack  out  N_REQ  one-cycle pulse to the granted requester; its byte has been taken
- ser_strobe  out  1  one-cycle load pulse to the converter
- ser_data  out  WIDTH  registered byte to the converter's parallel input; held until next load
- grant_id  out  clog2(N_REQ)  index of the most recently granted requester
- busy  out  1  high while a frame is in LOAD, SHIFT or GAP
- frame_done  out  1  one-cycle pulse in the last SHIFT cycle

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state=IDLE, round-robin pointer=0, counter=0. Reset mid-frame aborts the frame; no ack or frame_done is issued for it afterwards.
- States and transitions:
  - IDLE: req sampled. If req==0, stay in IDLE. Otherwise the winner w is the first set bit searching from pointer upward with wrap-around. At the next edge:
    - state=LOAD;
    - ser_data=data[w], grant_id=w;
    - ack[w]=1, ser_strobe=1, busy=1;
    - pointer=(w+1) mod N_REQ.
  - LOAD: lasts exactly 1 cycle; ack/strobe are high only here. Next: SHIFT, counter=0.
  - SHIFT: lasts SHIFT_LEN cycles; counter increments each cycle. frame_done=1 when counter==SHIFT_LEN-1. Next: GAP if GAP_LEN>0, otherwise IDLE.
  - GAP: lasts GAP_LEN cycles, then IDLE.
- busy: 0 only in IDLE.
- Latency: req high in IDLE cycle k gives ack/strobe in cycle k+1.
- Frame period: with continuous requests, strobe-to-strobe spacing = 2+SHIFT_LEN+GAP_LEN cycles (11 with default parameters).
- Requester rules:
  - Hold req and data stable until ack.
  - Drop req in the cycle after ack unless another byte is pending. A req still high in the next IDLE is treated as a new request.
  - req is ignored outside IDLE. Raising or dropping req during LOAD/SHIFT/GAP has no effect.
  - Withdrawing req before grant is legal.
- Simultaneous requests: exactly one ack per frame; no requester waits more than N_REQ frames while continuously requesting.
- ser_data and grant_id hold their values after the frame until the next LOAD.
- Counter width: clog2(max(SHIFT_LEN,GAP_LEN)+1) bits; no wrap within a state.

Test Plan:
1. Single request: after reset release, req=4'b0001, data[0]=8'hA5 → next cycle ack=4'b0001, ser_strobe=1, ser_data=8'hA5, grant_id=0. frame_done 8 cycles later; busy high 10 cycles.
2. Simultaneous requests: req=4'b1010 held with each requester dropping after its ack → grants in order 1 then 3, strobes 11 cycles apart, ser_data follows each requester's byte.
3. Fairness: all four req held high for 8 frames → grant_id sequence 0,1,2,3,0,1,2,3. Exactly one ack bit per frame; strobe spacing 11.
4. Ignored request: req[2] raised during SHIFT and dropped before IDLE → no ack[2], busy falls after GAP, state stays IDLE.
5. Reset mid-frame: rst=0 at SHIFT counter=4 → all outputs 0 immediately (asynchronously). After release, req=4'b0100 gives grant_id=2, with pointer restarted at 0.
6. GAP_LEN=0, SHIFT_LEN=3, continuous req=4'b0001 → strobe every 5 cycles, frame_done in the cycle before each IDLE.
